// File: rtl/dct_1d_coeff_reader.sv
// dct_1d_coeff_reader
//   Reader side of the DCT cosine-coefficient ROM. It collects 8 signed
//   samples and then computes the 8-point 1D DCT X[k] for k = 0..7. Each
//   X[k] takes 8 MAC cycles (one ROM lookup per term). The rounded and
//   saturated result is held on the output until it is accepted.
//   Two instances, with a transpose buffer between them, form the 2D DCT.
// Ports
//   clk, rst            rising-edge clock, async active-high reset
//   in_valid/in_ready   sample handshake, in_data = x[n] in arrival order
//   rom_addr/rom_enb    ROM address m and decoder enable (asserted in MAC)
//   rom_cn              unsigned Q1.15 |coef|, combinational from the address
//   out_valid/out_ready coefficient handshake
//   out_data/out_index  saturated X[k] and its k
module dct_1d_coeff_reader #(
  parameter int DATA_W = 12,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = DATA_W + 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic [2:0]               rom_addr,
  output logic                     rom_enb,
  input  logic [15:0]              rom_cn,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [2:0]               out_index
);

  typedef enum logic [1:0] {LOAD, MAC, OUT} state_t;

  localparam int TERM_W = DATA_W + 17;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(16384);
  localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t state, state_nx;
  logic signed [DATA_W-1:0] smp [8];
  logic [2:0] n, k;
  logic signed [ACC_W-1:0] acc;

  // Coefficient index fold. The 5-bit product wraps mod 32 by itself.
  // Subtracting from zero in 5 bits gives 32-p for p in 17..31.
  logic [4:0] p, mf, mi;
  logic       neg, zero;
  assign p    = {1'b0, n, 1'b1} * {2'b00, k};
  assign mf   = (p > 5'd16) ? (5'd0 - p) : p;
  assign neg  = (mf > 5'd8);
  assign mi   = neg ? (5'd16 - mf) : mf;
  assign zero = (mi == 5'd8);   // cos(pi/2): contributes nothing

  logic signed [TERM_W-1:0] term;
  logic signed [ACC_W-1:0]  term_ext, acc_sum, rnd_pre, rnd;
  logic signed [OUT_W-1:0]  sat_val;

  assign term     = smp[n] * $signed({1'b0, rom_cn});
  always_comb begin
    term_ext = {{(ACC_W-TERM_W){term[TERM_W-1]}}, term};
    if (zero)     term_ext = '0;
    else if (neg) term_ext = -term_ext;
  end
  assign acc_sum = acc + term_ext;
  assign rnd_pre = acc_sum + HALF;
  assign rnd     = rnd_pre >>> 15;
  assign sat_val = (rnd > OMAX) ? OMAX[OUT_W-1:0] :
                   (rnd < OMIN) ? OMIN[OUT_W-1:0] : rnd[OUT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    rom_enb   = 1'b0;
    rom_addr  = 3'd0;
    out_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && n == 3'd7) state_nx = MAC;
      end
      MAC: begin
        rom_enb = 1'b1;
        if (!zero) rom_addr = mi[2:0];
        if (n == 3'd7) state_nx = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = (k == 3'd7) ? LOAD : MAC;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n         <= '0;
      k         <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_index <= '0;
      for (int i = 0; i < 8; i++) smp[i] <= '0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          smp[n] <= in_data;
          n      <= n + 3'd1;   // wraps to 0 after the 8th sample
          if (n == 3'd7) begin
            k   <= '0;
            acc <= '0;
          end
        end
        MAC: begin
          n   <= n + 3'd1;
          acc <= acc_sum;
          if (n == 3'd7) begin
            out_data  <= sat_val;
            out_index <= k;
          end
        end
        OUT: if (out_ready) begin
          if (k != 3'd7) k <= k + 3'd1;
          acc <= '0;
          n   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
